// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: register offsets, STATUS bit positions
// and the receive FSM encoding.
package uart_pkg;

    localparam logic [1:0] RX_DATA = 2'd0;
    localparam logic [1:0] RX_STAT = 2'd1;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_FRAME_ERR = 2;
    localparam int unsigned STAT_OVERRUN   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/rx_fifo_sync.sv
// DEPTH x 8 synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and overflow pulses.
module rx_fifo_sync #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign head     = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_rx_simp_bus.sv
// 8N1 UART receiver on the simple external bus: synchronizer, bit-timing FSM,
// receive FIFO and a 4-entry register window.
module uart_rx_simp_bus
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] adr,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic [7:0] dout,
    input  logic       rx_p
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          rx_s1_q, rx_sync_q, rx_prev_q;
    logic          overrun_q, frame_err_q;
    logic          push, frame_set, pop, clr;
    logic          fifo_full, fifo_empty, fifo_overflow;
    logic [7:0]    fifo_head;
    logic [7:0]    status;
    logic [5:0]    unused_din;

    assign unused_din = din[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_p;
            rx_sync_q <= rx_s1_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Falling edge only: after a frame error the line must go high first.
                if (!rx_sync_q && rx_prev_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_sync_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    state_d   = StIdle;
                    push      = rx_sync_q;
                    frame_set = !rx_sync_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop = wr_en && (adr == RX_STAT) && din[0];
    assign clr = wr_en && (adr == RX_STAT) && din[1];

    rx_fifo_sync #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (shreg_q),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .overflow(fifo_overflow)
    );

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= fifo_overflow || (overrun_q && !clr);
            frame_err_q <= frame_set || (frame_err_q && !clr);
        end
    end

    always_comb begin
        status                 = '0;
        status[STAT_NOT_EMPTY] = !fifo_empty;
        status[STAT_FULL]      = fifo_full;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_OVERRUN]   = overrun_q;
    end

    always_comb begin
        dout = 8'h00;
        case (adr)
            RX_DATA: dout = fifo_empty ? 8'h00 : fifo_head;
            RX_STAT: dout = status;
            default: dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_simp_bus.sv
// Directed bench for uart_rx_simp_bus with CLKS_PER_BIT=8, DEPTH=4.
module tb_uart_rx_simp_bus;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] adr = 2'd0;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic [7:0] dout;
    logic       rx_p = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_simp_bus #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .adr  (adr),
        .din  (din),
        .wr_en(wr_en),
        .dout (dout),
        .rx_p (rx_p)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
        adr = a;
        #1;
        v = dout;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        adr   = a;
        din   = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Start bit driven just after edge P; the stop sample lands on edge P+79.
    // pre_stat is STATUS before that edge, post_stat one cycle after it.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop,
                              output logic [7:0] pre_stat, output logic [7:0] post_stat);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            rx_p = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_p = f[9];
        repeat (CPB - 2) @(posedge clk);
        #1;
        adr = 2'd1;
        #1;
        pre_stat = dout;
        if (pop_at_stop) begin
            din   = 8'h01;
            wr_en = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        post_stat = dout;
        rx_p = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] s0, s1;
        send_frame(b, 1'b1, 1'b0, s0, s1);
    endtask

    logic [7:0] v, pre, post;
    logic [7:0] exp_pops [4];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and the unused window
        read_reg(2'd0, v); check_eq("rst_rxdata", v, 8'h00);
        read_reg(2'd1, v); check_eq("rst_status", v, 8'h00);

        // 1: single byte, exact visibility
        send_frame(8'hA5, 1'b1, 1'b0, pre, post);
        check_eq("t1_pre_stop_status", pre, 8'h00);
        check_eq("t1_post_stop_status", post, 8'h01);
        read_reg(2'd0, v); check_eq("t1_rxdata", v, 8'hA5);
        read_reg(2'd2, v); check_eq("t1_adr2", v, 8'h00);
        read_reg(2'd3, v); check_eq("t1_adr3", v, 8'h00);
        bus_write(2'd0, 8'h03);
        bus_write(2'd2, 8'h03);
        read_reg(2'd1, v); check_eq("t1_ignored_writes", v, 8'h01);
        bus_write(2'd1, 8'h01);
        read_reg(2'd1, v); check_eq("t1_status_after_pop", v, 8'h00);
        read_reg(2'd0, v); check_eq("t1_rxdata_after_pop", v, 8'h00);
        bus_write(2'd1, 8'h01);
        read_reg(2'd1, v); check_eq("t1_pop_empty", v, 8'h00);

        // 2: fill, overrun, drain
        for (int i = 1; i <= 4; i++) send(8'(i));
        read_reg(2'd1, v); check_eq("t2_full", v, 8'h03);
        send(8'h05);
        read_reg(2'd1, v); check_eq("t2_overrun", v, 8'h0B);
        for (int i = 1; i <= 4; i++) begin
            read_reg(2'd0, v); check_eq($sformatf("t2_pop%0d", i), v, 8'(i));
            bus_write(2'd1, 8'h01);
        end
        read_reg(2'd1, v); check_eq("t2_drained", v, 8'h08);
        read_reg(2'd0, v); check_eq("t2_rxdata_empty", v, 8'h00);
        bus_write(2'd1, 8'h02);
        read_reg(2'd1, v); check_eq("t2_cleared", v, 8'h00);

        // 3: framing error, clear, recovery
        send_frame(8'h3C, 1'b0, 1'b0, pre, post);
        read_reg(2'd1, v); check_eq("t3_frame_err", v, 8'h04);
        bus_write(2'd1, 8'h02);
        read_reg(2'd1, v); check_eq("t3_cleared", v, 8'h00);
        send(8'h7E);
        read_reg(2'd1, v); check_eq("t3_status", v, 8'h01);
        read_reg(2'd0, v); check_eq("t3_rxdata", v, 8'h7E);
        bus_write(2'd1, 8'h01);

        // 4: short glitch rejected
        @(posedge clk);
        #1;
        rx_p = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_p = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        read_reg(2'd1, v); check_eq("t4_glitch_status", v, 8'h00);
        send(8'h55);
        read_reg(2'd1, v); check_eq("t4_status", v, 8'h01);
        read_reg(2'd0, v); check_eq("t4_rxdata", v, 8'h55);
        bus_write(2'd1, 8'h01);

        // 5: pop coincides with push into a full FIFO
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        read_reg(2'd1, v); check_eq("t5_full", v, 8'h03);
        send_frame(8'h99, 1'b1, 1'b1, pre, post);
        check_eq("t5_post_status", post, 8'h03);
        read_reg(2'd1, v); check_eq("t5_status", v, 8'h03);
        exp_pops[0] = 8'h20; exp_pops[1] = 8'h30; exp_pops[2] = 8'h40; exp_pops[3] = 8'h99;
        for (int i = 0; i < 3; i++) begin
            read_reg(2'd0, v); check_eq($sformatf("t5_pop%0d", i), v, exp_pops[i]);
            bus_write(2'd1, 8'h01);
        end
        read_reg(2'd0, v); check_eq("t5_last", v, exp_pops[3]);
        read_reg(2'd1, v); check_eq("t5_one_left", v, 8'h01);

        // 6: reset in the middle of bit 4 of 0xFF
        @(posedge clk);
        #1;
        rx_p = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        rx_p = 1'b1;
        repeat (4 * CPB + 3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_reg(2'd1, v); check_eq("t6_after_rst", v, 8'h00);
        read_reg(2'd0, v); check_eq("t6_rxdata_rst", v, 8'h00);
        repeat (4) @(posedge clk);
        send(8'h12);
        read_reg(2'd1, v); check_eq("t6_status", v, 8'h01);
        read_reg(2'd0, v); check_eq("t6_rxdata", v, 8'h12);
        bus_write(2'd1, 8'h01);
        read_reg(2'd1, v); check_eq("t6_final", v, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
